// File: rtl/serial_deserializer_16bit.sv
// Serial-in, parallel-out receiver: reassembles framed MSB- or LSB-first bit streams
// into WIDTH-bit words presented on a one-entry valid/ready holding register.
module serial_deserializer_16bit #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ser_in,
    input  logic                       ser_valid,
    input  logic                       frame_start,
    input  logic                       msb_first,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic             order_msb;

    logic             start_bit;
    logic             step_bit;
    logic             word_done;
    logic             out_free;
    logic [WIDTH-1:0] shift_next;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                  input logic             b,
                                                  input logic             msb);
        if (msb)
            shift_in = {sr[WIDTH-2:0], b};
        else
            shift_in = {b, sr[WIDTH-1:1]};
    endfunction

    // A frame_start bit always begins from a cleared register so an aborted frame leaves no residue.
    always_comb begin
        start_bit  = ser_valid && frame_start;
        step_bit   = ser_valid && !frame_start && (state == SHIFT);
        word_done  = step_bit && (bit_cnt == CW'(WIDTH-1));
        out_free   = !out_valid || out_ready;
        shift_next = start_bit ? shift_in('0, ser_in, msb_first)
                               : shift_in(shift_reg, ser_in, order_msb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            order_msb <= 1'b0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (start_bit) begin
                order_msb <= msb_first;
                shift_reg <= shift_next;
                bit_cnt   <= CW'(1);
                state     <= SHIFT;
                busy      <= 1'b1;
                frame_err <= (state == SHIFT);
            end else if (step_bit) begin
                shift_reg <= shift_next;
                if (word_done) begin
                    bit_cnt <= '0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end

            // Output stage: a completing word either loads (possibly replacing a consumed one) or is dropped.
            if (word_done && out_free) begin
                data_out  <= shift_next;
                out_valid <= 1'b1;
            end else begin
                if (word_done)
                    overrun <= 1'b1;
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule
